// File: rtl/srt4_seq.sv
// -----------------------------------------------------------------------------
// srt4_seq
// Control sequencer for an 8-bit radix-4 SRT divider. The datapath (P, A, B
// registers, shared 8-bit inbus/outbus) does all arithmetic; this block only
// walks the operation through its phases and emits one control vector per
// cycle.
//
// Operation: load P (dividend high byte), A (dividend low byte), B (divisor);
// normalise B until its MSB is set (or give up after NMAX shifts and flag a
// divide-by-zero); run ITERS radix-4 iterations with digits in {-2..+2};
// correct a negative remainder; shift the remainder back by the same number
// of normalisation steps; drive quotient then remainder onto outbus.
//
// Ports:
//   clk             in   rising-edge clock
//   rst_b           in   asynchronous active-low reset
//   beginSignal     in   start request, only looked at in IDLE
//   b7              in   B[7], divisor MSB, drives normalisation
//   msbp            in   P sign bit, drives remainder correction
//   p_top           in   P[8:6] (two's complement), selects the quotient digit
//   control_signals out  datapath control vector (bit map below)
//   endSignal       out  one-cycle completion pulse
//   divZero         out  divisor was zero; held until the next accepted start
//   busy            out  high in every state except IDLE
//
// Handshake: beginSignal is a level sampled on the rising edge while the
// sequencer sits in IDLE; once accepted it is ignored until the sequencer
// returns to IDLE. endSignal is high for exactly the DONE cycle.
//
// Control bit map:
//   c0 ldP   c1 ldA   c2 ldB   c3 normalise shift (B<<1, P:A<<1)
//   c4 P:A<<2        c5 +B    c6 -B    c7 +2B    c8 -2B
//   c9 q-digit write c10 digit negative  c11 digit magnitude 2
//   c12 correction (P+=B, Q-=1)  c13 P>>1  c14 outbus<=Q  c15 outbus<=P
//   c16 clear counters/Q
// -----------------------------------------------------------------------------
module srt4_seq #(
    parameter int CSW   = 17,
    parameter int ITERS = 4,
    parameter int NMAX  = 7
) (
    input  logic           clk,
    input  logic           rst_b,
    input  logic           beginSignal,
    input  logic           b7,
    input  logic           msbp,
    input  logic [2:0]     p_top,
    output logic [CSW-1:0] control_signals,
    output logic           endSignal,
    output logic           divZero,
    output logic           busy
);

    // Control bit positions.
    localparam int C_LDP   = 0;
    localparam int C_LDA   = 1;
    localparam int C_LDB   = 2;
    localparam int C_NORM  = 3;
    localparam int C_SH2   = 4;
    localparam int C_ADDB  = 5;
    localparam int C_SUBB  = 6;
    localparam int C_ADD2B = 7;
    localparam int C_SUB2B = 8;
    localparam int C_QWR   = 9;
    localparam int C_QNEG  = 10;
    localparam int C_QMAG2 = 11;
    localparam int C_CORR  = 12;
    localparam int C_DENRM = 13;
    localparam int C_OUTQ  = 14;
    localparam int C_OUTR  = 15;
    localparam int C_CLR   = 16;

    localparam logic [2:0] NMAX_C     = 3'(NMAX);
    localparam logic [1:0] ITER_LAST  = 2'(ITERS - 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LD_P   = 4'd1,
        S_LD_A   = 4'd2,
        S_LD_B   = 4'd3,
        S_NORM   = 4'd4,
        S_ITER   = 4'd5,
        S_CORR   = 4'd6,
        S_DENORM = 4'd7,
        S_OUT_Q  = 4'd8,
        S_OUT_R  = 4'd9,
        S_DONE   = 4'd10
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     cnt1_q, cnt1_d;   // normalisation shifts taken
    logic [1:0]     cnt2_q, cnt2_d;   // iteration index
    logic           dz_q, dz_d;
    logic [CSW-1:0] ctrl_d;
    logic           end_d;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= S_IDLE;
            cnt1_q  <= 3'd0;
            cnt2_q  <= 2'd0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt1_q  <= cnt1_d;
            cnt2_q  <= cnt2_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt1_d  = cnt1_q;
        cnt2_d  = cnt2_q;
        dz_d    = dz_q;
        ctrl_d  = '0;
        end_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                ctrl_d[C_CLR] = 1'b1;
                cnt1_d        = 3'd0;
                cnt2_d        = 2'd0;
                if (beginSignal) begin
                    state_d = S_LD_P;
                    dz_d    = 1'b0;
                end
            end

            S_LD_P: begin
                ctrl_d[C_LDP] = 1'b1;
                state_d       = S_LD_A;
            end

            S_LD_A: begin
                ctrl_d[C_LDA] = 1'b1;
                state_d       = S_LD_B;
            end

            S_LD_B: begin
                ctrl_d[C_LDB] = 1'b1;
                state_d       = S_NORM;
            end

            S_NORM: begin
                if (b7) begin
                    state_d = S_ITER;
                    cnt2_d  = 2'd0;
                end else if (cnt1_q != NMAX_C) begin
                    ctrl_d[C_NORM] = 1'b1;
                    cnt1_d         = cnt1_q + 3'd1;
                end else begin
                    // B never acquired a leading one: the divisor is zero.
                    dz_d    = 1'b1;
                    state_d = S_DONE;
                end
            end

            S_ITER: begin
                ctrl_d[C_SH2] = 1'b1;
                ctrl_d[C_QWR] = 1'b1;
                // Digit selection straight from the current P top bits.
                // A positive digit subtracts that multiple of B, a negative
                // digit adds it back.
                case (p_top)
                    3'b001: ctrl_d[C_SUBB] = 1'b1;
                    3'b010,
                    3'b011: begin
                        ctrl_d[C_SUB2B] = 1'b1;
                        ctrl_d[C_QMAG2] = 1'b1;
                    end
                    3'b100,
                    3'b101: begin
                        ctrl_d[C_ADD2B] = 1'b1;
                        ctrl_d[C_QNEG]  = 1'b1;
                        ctrl_d[C_QMAG2] = 1'b1;
                    end
                    3'b110: begin
                        ctrl_d[C_ADDB] = 1'b1;
                        ctrl_d[C_QNEG] = 1'b1;
                    end
                    default: ;  // 000 and 111 select digit 0
                endcase
                if (cnt2_q == ITER_LAST) begin
                    state_d = S_CORR;
                end else begin
                    cnt2_d = cnt2_q + 2'd1;
                end
            end

            S_CORR: begin
                ctrl_d[C_CORR] = msbp;
                state_d        = S_DENORM;
            end

            S_DENORM: begin
                // Undo exactly as many shifts as normalisation applied.
                if (cnt1_q != 3'd0) begin
                    ctrl_d[C_DENRM] = 1'b1;
                    cnt1_d          = cnt1_q - 3'd1;
                end else begin
                    state_d = S_OUT_Q;
                end
            end

            S_OUT_Q: begin
                ctrl_d[C_OUTQ] = 1'b1;
                state_d        = S_OUT_R;
            end

            S_OUT_R: begin
                ctrl_d[C_OUTR] = 1'b1;
                state_d        = S_DONE;
            end

            S_DONE: begin
                end_d   = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are forced low while reset is asserted, so an abort silences the
    // datapath in the same cycle rather than at the next clock edge.
    assign control_signals = rst_b ? ctrl_d : '0;
    assign endSignal       = rst_b & end_d;
    assign busy            = rst_b & (state_q != S_IDLE);
    assign divZero         = dz_q;

endmodule

// File: tb/tb_srt4_seq.sv
module tb_srt4_seq;

  localparam logic [16:0] C0  = 17'd1 << 0;
  localparam logic [16:0] C1  = 17'd1 << 1;
  localparam logic [16:0] C2  = 17'd1 << 2;
  localparam logic [16:0] C3  = 17'd1 << 3;
  localparam logic [16:0] C4  = 17'd1 << 4;
  localparam logic [16:0] C5  = 17'd1 << 5;
  localparam logic [16:0] C6  = 17'd1 << 6;
  localparam logic [16:0] C7  = 17'd1 << 7;
  localparam logic [16:0] C8  = 17'd1 << 8;
  localparam logic [16:0] C9  = 17'd1 << 9;
  localparam logic [16:0] C10 = 17'd1 << 10;
  localparam logic [16:0] C11 = 17'd1 << 11;
  localparam logic [16:0] C12 = 17'd1 << 12;
  localparam logic [16:0] C13 = 17'd1 << 13;
  localparam logic [16:0] C14 = 17'd1 << 14;
  localparam logic [16:0] C15 = 17'd1 << 15;
  localparam logic [16:0] C16 = 17'd1 << 16;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_b;
  logic        beginSignal;
  logic        b7;
  logic        msbp;
  logic [2:0]  p_top;
  logic [16:0] control_signals;
  logic        endSignal;
  logic        divZero;
  logic        busy;

  always #5 clk = ~clk;

  srt4_seq dut (
    .clk             (clk),
    .rst_b           (rst_b),
    .beginSignal     (beginSignal),
    .b7              (b7),
    .msbp            (msbp),
    .p_top           (p_top),
    .control_signals (control_signals),
    .endSignal       (endSignal),
    .divZero         (divZero),
    .busy            (busy)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  // entry = {ctrl[16:0], endSignal, busy, divZero}
  logic [19:0] exp_q[$];
  logic [19:0] cur_e;
  int          cur_cycle = 0;
  logic [16:0] obs[0:63];
  int c3_cnt, c12_cnt, c13_cnt, cout_cnt, end_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Quotient digit from the signed value of P[8:6], then the datapath
  // operation it implies: digit d means subtract d*B from the partial remainder.
  function automatic logic [16:0] digit_ctrl(input logic [2:0] pt);
    int v;
    int d;
    v = pt[2] ? int'(pt) - 8 : int'(pt);
    if (v >= 0) d = (v > 2) ? 2 : v;
    else        d = (v + 1 < -2) ? -2 : v + 1;
    digit_ctrl = C4 | C9;
    if (d > 0)      digit_ctrl = digit_ctrl | ((d == 1) ? C6 : (C8 | C11));
    else if (d < 0) digit_ctrl = digit_ctrl | ((d == -1) ? (C5 | C10) : (C7 | C10 | C11));
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur_e = exp_q.pop_front();
      check($sformatf("ctrl@%0d", cur_cycle), 32'(control_signals), 32'(cur_e[19:3]));
      check($sformatf("end@%0d", cur_cycle), 32'(endSignal), 32'(cur_e[2]));
      check($sformatf("busy@%0d", cur_cycle), 32'(busy), 32'(cur_e[1]));
      check($sformatf("divZero@%0d", cur_cycle), 32'(divZero), 32'(cur_e[0]));
      obs[cur_cycle] = control_signals;
      c3_cnt   += int'(control_signals[3]);
      c12_cnt  += int'(control_signals[12]);
      c13_cnt  += int'(control_signals[13]);
      cout_cnt += int'(control_signals[14] | control_signals[15]);
      if (endSignal) end_cyc = cur_cycle;
    end
  end

  // ---------------- driver: one full operation ----------------
  // pts = {digit0, digit1, digit2, digit3} p_top values for the ITER cycles.
  task automatic run_op(input logic [7:0] dv, input logic [11:0] pts,
                        input logic m_corr, input logic m_noise,
                        input logic begin_mid, input logic hold_end,
                        input logic prev_dz);
    logic [19:0] ea[0:40];
    logic [7:0]  t;
    int k, last, it0, corr_cyc;
    c3_cnt = 0; c12_cnt = 0; c13_cnt = 0; cout_cnt = 0; end_cyc = -1;
    for (int i = 0; i < 41; i++) ea[i] = '0;
    // expected trace built from the operation's phase sequence
    ea[0] = {C16, 1'b0, 1'b0, prev_dz};
    ea[1] = {C0, 3'b010};
    ea[2] = {C1, 3'b010};
    ea[3] = {C2, 3'b010};
    if (dv == 8'h00) begin
      k = 7;
      for (int j = 0; j < 7; j++) ea[4 + j] = {C3, 3'b010};
      ea[11] = {17'd0, 3'b010};
      ea[12] = {17'd0, 3'b111};
      last = 12; it0 = -100; corr_cyc = -100;
    end else begin
      k = 0; t = dv;
      while (!t[7]) begin t = t << 1; k++; end
      for (int j = 0; j < k; j++) ea[4 + j] = {C3, 3'b010};
      ea[4 + k] = {17'd0, 3'b010};
      it0 = 5 + k;
      for (int i = 0; i < 4; i++) ea[it0 + i] = {digit_ctrl(pts[3*(3-i) +: 3]), 3'b010};
      corr_cyc = 9 + k;
      ea[corr_cyc] = {(m_corr ? C12 : 17'd0), 3'b010};
      for (int j = 0; j < k; j++) ea[10 + k + j] = {C13, 3'b010};
      ea[10 + 2*k] = {17'd0, 3'b010};
      ea[11 + 2*k] = {C14, 3'b010};
      ea[12 + 2*k] = {C15, 3'b010};
      ea[13 + 2*k] = {17'd0, 3'b110};
      last = 13 + 2*k;
    end
    for (int n = 0; n <= last; n++) begin
      @(posedge clk); #1;
      beginSignal = (n == 0) || (begin_mid && n == 6) || (hold_end && n == last);
      if (dv == 8'h00) b7 = 1'b0;
      else if (n < 4) b7 = 1'b0;
      else if (n <= 4 + k) begin t = dv << (n - 4); b7 = t[7]; end
      else b7 = 1'b1;
      if (n >= it0 && n < it0 + 4) p_top = pts[3*(3-(n-it0)) +: 3];
      else p_top = 3'($urandom_range(0, 7));
      msbp = (n == corr_cyc) ? m_corr : m_noise;
      cur_cycle = n;
      exp_q.push_back(ea[n]);
    end
    @(negedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_b = 1'b0; beginSignal = 1'b0; b7 = 1'b0; msbp = 1'b0; p_top = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", 32'(control_signals), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_end", 32'(endSignal), 32'd0);
    check("rst_dz", 32'(divZero), 32'd0);
    rst_b = 1'b1;
    #1;
    check("idle_ctrl", 32'(control_signals), 32'(C16));

    // model pins: digit table against hand-computed vectors
    check("model_d001", 32'(digit_ctrl(3'b001)), 32'h00250);
    check("model_d101", 32'(digit_ctrl(3'b101)), 32'h00E90);

    // divisor 0x80: no normalisation, digits +1,+2,-1,0
    run_op(8'h80, {3'b001, 3'b010, 3'b110, 3'b000}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t1_iter0", 32'(obs[5]), 32'h00250);
    check("t1_iter1", 32'(obs[6]), 32'h00B10);
    check("t1_iter2", 32'(obs[7]), 32'h00630);
    check("t1_iter3", 32'(obs[8]), 32'h00210);
    check("t1_c3", c3_cnt, 0);
    check("t1_c12", c12_cnt, 0);
    check("t1_end", end_cyc, 13);

    // divisor 0x05: five normalisation shifts, correction taken
    run_op(8'h05, {3'b011, 3'b100, 3'b101, 3'b111}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t2_c3", c3_cnt, 5);
    check("t2_c13", c13_cnt, 5);
    check("t2_c12", c12_cnt, 1);
    check("t2_iter0", 32'(obs[10]), 32'h00B10);
    check("t2_iter1", 32'(obs[11]), 32'h00E90);
    check("t2_end", end_cyc, 23);

    // divisor 0: divide-by-zero, begin held through DONE
    run_op(8'h00, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t3_c3", c3_cnt, 7);
    check("t3_out", cout_cnt, 0);
    check("t3_end", end_cyc, 12);
    check("t3_dz", 32'(divZero), 32'd1);

    // back-to-back start, msbp noise everywhere, begin pulsed in ITER
    run_op(8'h40, {3'b111, 3'b110, 3'b001, 3'b100}, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check("t4_c12", c12_cnt, 1);
    check("t4_c13", c13_cnt, 1);
    check("t4_end", end_cyc, 15);

    // divisor 0x01: leading one arrives on the last allowed shift
    run_op(8'h01, {3'b010, 3'b000, 3'b110, 3'b011}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t5_c3", c3_cnt, 7);
    check("t5_c13", c13_cnt, 7);
    check("t5_end", end_cyc, 27);
    check("t5_dz", 32'(divZero), 32'd0);

    // reset in the middle of ITER (cnt2 = 2)
    @(posedge clk); #1;
    beginSignal = 1'b1; b7 = 1'b1; msbp = 1'b0; p_top = 3'b000;
    for (int n = 1; n <= 7; n++) begin
      @(posedge clk); #1;
      beginSignal = 1'b0;
    end
    @(negedge clk);
    check("abort_pre_ctrl", 32'(control_signals), 32'(C4 | C9));
    check("abort_pre_busy", 32'(busy), 32'd1);
    #2;
    rst_b = 1'b0;
    #1;
    check("abort_ctrl", 32'(control_signals), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_end", 32'(endSignal), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      check($sformatf("post_abort_ctrl%0d", n), 32'(control_signals), 32'(C16));
      check($sformatf("post_abort_end%0d", n), 32'(endSignal), 32'd0);
      check($sformatf("post_abort_busy%0d", n), 32'(busy), 32'd0);
    end

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/srt4_seq.md
Name: srt4_seq

Overview:
Control sequencer for the 8-bit radix-4 SRT divider datapath (P, A, B registers, shared 8-bit inbus/outbus).
- Loads the 16-bit dividend (P:A) and the 8-bit divisor (B).
- Normalizes B and runs four radix-4 iterations with digits {-2..+2}.
- Corrects a negative remainder, denormalizes it, then drives quotient and remainder onto outbus.
- Emits one 17-bit control vector per cycle plus endSignal. The datapath performs all arithmetic.

Parameters:
CSW, 17, control vector width
ITERS, 4, radix-4 iterations (8 quotient bits)
NMAX, 7, max normalization shifts before divide-by-zero

Ports:
clk  in  1  clock, rising edge
rst_b  in  1  asynchronous active-low reset
beginSignal  in  1  start request, sampled in IDLE only
b7  in  1  B[7] (divisor MSB)
msbp  in  1  P sign bit
p_top  in  3  P[8:6], two's-complement, for digit selection
control_signals  out  CSW  datapath controls
endSignal  out  1  one-cycle completion pulse
divZero  out  1  divisor was zero
busy  out  1  high in every state except IDLE

Behaviour:
Control bits:
- c0 ldP, c1 ldA, c2 ldB, c3 normalize shift (B<<1, P:A<<1).
- c4 shift P:A left 2.
- c5 +B, c6 -B, c7 +2B, c8 -2B. Applied after the c4 shift, same cycle.
- c9 q-digit write, c10 digit negative, c11 digit magnitude 2.
- c12 correction (P+=B, Q-=1), c13 P>>1 (denormalize), c14 outbus<=Q, c15 outbus<=P, c16 clear counters/Q.
- All bits are 0 unless listed for the current state.

Reset:
- State goes to IDLE; control_signals=0, endSignal=0, divZero=0, busy=0, cnt1=0, cnt2=0.
- Reset mid-operation aborts immediately. No partial result and no endSignal are produced.

States and transitions:
- IDLE: c16=1. If beginSignal=1 -> LD_P, and clear divZero. beginSignal is ignored in all other states.
- LD_P: c0 (inbus = dividend high byte) -> LD_A.
- LD_A: c1 (dividend low byte) -> LD_B.
- LD_B: c2 (divisor) -> NORM.
- NORM:
  - b7=1: no control bits -> ITER, cnt2=0.
  - b7=0 and cnt1<NMAX: c3, cnt1++, stay in NORM.
  - b7=0 and cnt1=NMAX: divZero<=1 -> DONE.
- ITER: c4 and c9 every cycle; cnt2++. When cnt2=ITERS-1 -> CORR. Digit is selected from p_top, combinationally (Mealy):
  - 000 -> 0 (no add/sub)
  - 001 -> +1: c6
  - 010, 011 -> +2: c8, c11
  - 100, 101 -> -2: c7, c10, c11
  - 110 -> -1: c5, c10
  - 111 -> 0
- CORR: c12 only if msbp=1. Always one cycle -> DENORM.
- DENORM: if cnt1>0, assert c13 and cnt1--, stay. If cnt1=0 -> OUT_Q.
- OUT_Q: c14 -> OUT_R.
- OUT_R: c15 -> DONE.
- DONE: endSignal=1 for exactly one cycle -> IDLE.
  - On divide-by-zero, OUT_Q and OUT_R are skipped; outbus is not driven.
  - divZero holds until the next accepted beginSignal.

Timing:
- Latency from the edge that samples beginSignal to the endSignal cycle is 13+2k cycles, where k = normalization shifts.
- Divide-by-zero: endSignal in cycle 12.
- beginSignal held high in DONE or IDLE starts the next operation: one IDLE cycle, then LD_P.
- cnt1 is 3 bits and cnt2 is 2 bits. Neither wraps, because of the guards above.

Test Plan:
- rst_b=0 mid-ITER (cnt2=2) -> control_signals=0 and busy=0 within the same cycle; after release, state is IDLE and no endSignal.
- Divisor 0x80 (b7=1 at NORM), p_top sequence 001,010,110,000, msbp=0:
  - no c3 asserted;
  - ITER vectors c4|c9|c6, c4|c9|c8|c11, c4|c9|c5|c10, c4|c9;
  - no c12;
  - endSignal in cycle 13.
- Divisor 0x05 (b7 goes high after 5 shifts):
  - exactly 5 NORM cycles with c3;
  - exactly 5 DENORM cycles with c13;
  - endSignal in cycle 23.
- Divisor 0x00 (b7 stays 0) -> 7 cycles of c3, then DONE; divZero=1, endSignal in cycle 12, c14/c15 never asserted.
- msbp=1 in CORR -> c12 asserted for exactly one cycle; msbp=1 in any other state has no effect.
- beginSignal pulsed during ITER -> ignored; held high through DONE -> IDLE for one cycle, then LD_P with divZero cleared.
